// File: rtl/dodge_game_ctrl.sv
// Game sequencer for the dodge game: detects Enter presses and walks IDLE/START/PLAY/LOST.
// It paces the playfield with a shrinking step period and keeps a saturating score.
module dodge_game_ctrl #(
  parameter int unsigned TICK_BASE = 1_000_000,
  parameter int unsigned TICK_DEC  = 50_000,
  parameter int unsigned TICK_MIN  = 250_000,
  parameter int unsigned CW        = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       collision,
  output logic       on,
  output logic       done,
  output logic [7:0] score,
  output logic       step,
  output logic       clear
);

  localparam int unsigned SW = 8;
  localparam logic [CW-1:0] BASE    = CW'(TICK_BASE);
  localparam logic [CW-1:0] BASE_M1 = CW'(TICK_BASE - 1);
  localparam logic [CW-1:0] DEC     = CW'(TICK_DEC);
  localparam logic [CW-1:0] MIN     = CW'(TICK_MIN);
  localparam logic [SW-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    LOST  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            enter_q, enter_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   period_q, period_d;
  logic [SW-1:0]   score_q, score_d;
  logic            step_q, step_d;
  logic            clear_q, clear_d;
  logic            on_q, on_d;
  logic            done_q, done_d;
  logic            press;
  logic [SW-1:0]   score_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      enter_q  <= 1'b1;
      cnt_q    <= '0;
      period_q <= BASE;
      score_q  <= '0;
      step_q   <= 1'b0;
      clear_q  <= 1'b0;
      on_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      enter_q  <= enter_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      score_q  <= score_d;
      step_q   <= step_d;
      clear_q  <= clear_d;
      on_q     <= on_d;
      done_q   <= done_d;
    end
  end

  // Next-state, counter and score logic; flag outputs decode the next state so they stay registered.
  always_comb begin
    state_d   = state_q;
    enter_d   = enter;
    cnt_d     = cnt_q;
    period_d  = period_q;
    score_d   = score_q;
    step_d    = 1'b0;
    clear_d   = 1'b0;
    on_d      = 1'b0;
    done_d    = 1'b0;
    press     = enter & ~enter_q;
    score_inc = score_q + SW'(1);

    case (state_q)
      IDLE, LOST: begin
        if (press) begin
          state_d  = START;
          score_d  = '0;
          period_d = BASE;
          cnt_d    = BASE_M1;
        end
      end
      START: begin
        state_d = PLAY;
      end
      PLAY: begin
        if (collision) begin
          state_d = LOST;
        end else if (cnt_q == '0) begin
          step_d = 1'b1;
          cnt_d  = period_q - CW'(1);
          if (score_q != SCORE_MAX) begin
            score_d = score_inc;
            // Speed up every 16 points; period never drops below the floor.
            if (score_inc[3:0] == 4'd0) begin
              period_d = ((period_q - MIN) >= DEC) ? (period_q - DEC) : MIN;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    clear_d = (state_d == START);
    on_d    = (state_d == PLAY);
    done_d  = (state_d == LOST);
  end

  assign on    = on_q;
  assign done  = done_q;
  assign score = score_q;
  assign step  = step_q;
  assign clear = clear_q;

endmodule

// File: doc/dodge_game_ctrl.md
# dodge_game_ctrl

Top-level sequencer for the dodge game; owns the game-state machine that drives the display block's `on`/`done`/`score` inputs. Detects Enter presses and paces the playfield with a programmable step tick. It also counts survived rows as the score and ends the game on a collision reported by the board logic. It sits between the keyboard/board logic and the screen-update block.

## Interface
- TICK_BASE, 1_000_000: initial step period in clk cycles (≥2)
- TICK_DEC, 50_000: period reduction applied per 16 points
- TICK_MIN, 250_000: lower bound on step period (≥2, ≤TICK_BASE)
- CW, 25: tick counter / period width; must hold TICK_BASE
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enter  in  1  Enter key level, already synchronized to clk
- collision  in  1  board logic: player overlaps obstacle (level)
- on  out  1  game in progress (PLAY)
- done  out  1  player lost (LOST)
- score  out  8  rows survived this game, saturating
- step  out  1  one-cycle pulse: advance playfield one row
- clear  out  1  one-cycle pulse: board logic reinitializes playfield

## Operation
- States: IDLE, START, PLAY, LOST; state register, outputs decoded from registered state/flops (glitch-free).
- enter_q flop; press = enter & ~enter_q. enter_q resets to 1, so a key held through reset does not start a game.
- IDLE: on=0, done=0. press → START.
- START (exactly 1 cycle): clear=1, score←0, period←TICK_BASE, cnt←TICK_BASE-1; → PLAY.
- PLAY: on=1. Each edge:
  - collision=1 → LOST; no step, no score change, regardless of cnt.
  - else cnt==0 → step←1, cnt←period-1 (pre-update period), score←score+1 unless score==8'hFF.
  - else cnt←cnt-1, step←0.
- Speed-up: on the edge where score increments to a value with score[3:0]==0, period←max(period-TICK_DEC, TICK_MIN); takes effect at the next reload. No speed-up while saturated.
- LOST: done=1, on=0, score held for display. press → START (new game). collision ignored.
- enter ignored in START/PLAY; collision ignored outside PLAY.
- period arithmetic in CW bits; compare before subtract so it never underflows.

## Timing
- Reset values: state=IDLE, on=0, done=0, score=0, step=0, clear=0, cnt=0, period=TICK_BASE, enter_q=1.
- Press sampled at edge N → START after N; clear high during the cycle N..N+1; PLAY after N+1.
- First PLAY cycle is index 0 (cnt=P-1); step high in PLAY cycle index P, then every P cycles; score increments on the same edge step rises.
- collision sampled at edge M in PLAY → on falls, done rises after M; a step scheduled for that edge is suppressed.
- step and clear never high in the same cycle; step never high outside PLAY.
- Reset asserted mid-game: outputs go to reset values asynchronously, no waiting for clk; after release, restart requires a fresh enter rising edge.

## Test plan
- Params TICK_BASE=4, TICK_DEC=1, TICK_MIN=2. Reset with enter held high, release, hold 10 cycles → stays IDLE, on=0, done=0; drop then raise enter → clear pulse 1 cycle, then on=1.
- In PLAY with collision=0, 20 cycles → step pulses every 4 cycles, score 0→1→2…, step single-cycle each time.
- Run to score 16 → subsequent step spacing 3 cycles; score 32 → 2 cycles; score 48 → stays 2 (floor).
- Force score to 8'hFF (long run) → score stays 8'hFF, steps continue.
- Assert collision on the cycle step would fire → no step, score unchanged, done=1, on=0; further collision/time → score held; enter press → clear, score=0, on=1.
- Assert reset asynchronously mid-PLAY between clk edges → on, step, score, done drop to 0 immediately; IDLE after release.
